// File: rtl/isa_pkg.sv
// Shared ISA constants for the 9-bit core: opcodes, the program terminator
// word and the loader state encoding.
package isa_pkg;

    localparam logic [2:0] OP_ADDI = 3'b000;
    localparam logic [2:0] OP_J    = 3'b001;
    localparam logic [2:0] OP_BR   = 3'b010;
    localparam logic [2:0] OP_MEM  = 3'b011;
    localparam logic [2:0] OP_SHF  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_ADD  = 3'b111;

    localparam logic [8:0] DONE_WORD = 9'h0F0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } load_state_t;

    // A mem-class bundle with both sub-op bits set is the program terminator.
    function automatic logic is_done_op(input logic [2:0] op, input logic [1:0] bb);
        return (op == OP_MEM) && (bb == 2'b11);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded instruction fields in, 9-bit machine
// word plus a field-overflow flag out.
module instr_pack
    import isa_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] bb,
    input  logic [2:0] rs,
    input  logic [2:0] rd,
    input  logic [5:0] imm,
    output logic [8:0] word,
    output logic       ovf
);

    always_comb begin
        word = {op, 6'd0};
        ovf  = 1'b0;
        case (op)
            OP_ADDI, OP_J: begin
                word[5:0] = imm;
            end
            OP_BR, OP_MEM: begin
                word[5:4] = bb;
                word[3]   = rs[0];
                word[2:0] = rd;
                ovf       = (rs > 3'd1);
            end
            OP_SHF: begin
                // Only bb[1] (direction) survives; the shift amount is 2 bits.
                word[5]   = bb[1];
                word[4:3] = rs[1:0];
                word[2:0] = rd;
                ovf       = rs[2];
            end
            default: begin
                word[5:3] = rs;
                word[2:0] = rd;
            end
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Instruction loader: packs field bundles into 9-bit words, writes them to
// consecutive imem addresses and terminates the program with the done word.
module prog_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [1:0]        in_bb,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rd,
    input  logic [5:0]        in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic              core_start,
    output logic              load_done,
    output logic              err
);

    // Top address is reserved for the done word, so this is the last user slot.
    localparam logic [ADDR_W-1:0] LAST_USER_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};

    load_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [8:0]        imem_wdata_reg;
    logic              core_start_reg;
    logic              load_done_reg;
    logic              err_reg;

    logic [8:0]        packed_word;
    logic              packed_ovf;
    logic              handshake;
    logic              done_op;
    logic              at_cap;

    instr_pack u_pack (
        .op   (in_op),
        .bb   (in_bb),
        .rs   (in_rs),
        .rd   (in_rd),
        .imm  (in_imm),
        .word (packed_word),
        .ovf  (packed_ovf)
    );

    assign handshake = in_valid && (state_reg == ST_LOAD);
    assign done_op   = is_done_op(in_op, in_bb);
    assign at_cap    = (addr_reg == LAST_USER_ADDR);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (load_go) state_next = ST_LOAD;
            ST_LOAD: begin
                if (handshake && (done_op || in_last || (!packed_ovf && at_cap)))
                    state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_DONE;
            ST_DONE:   if (load_go) state_next = ST_LOAD;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= '0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            core_start_reg <= 1'b1;
            load_done_reg  <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            imem_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (load_go) begin
                        addr_reg       <= '0;
                        err_reg        <= 1'b0;
                        load_done_reg  <= 1'b0;
                        core_start_reg <= 1'b1;
                    end else if (state_reg == ST_DONE) begin
                        // Released one cycle after the done word's strobe.
                        load_done_reg  <= 1'b1;
                        core_start_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (handshake && !done_op) begin
                        if (packed_ovf) begin
                            err_reg <= 1'b1;
                        end else begin
                            imem_we_reg    <= 1'b1;
                            imem_addr_reg  <= addr_reg;
                            imem_wdata_reg <= packed_word;
                            addr_reg       <= addr_reg + ADDR_W'(1);
                            if (!in_last && at_cap)
                                err_reg <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    imem_we_reg    <= 1'b1;
                    imem_addr_reg  <= addr_reg;
                    imem_wdata_reg <= DONE_WORD;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_LOAD);
    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign core_start = core_start_reg;
    assign load_done  = load_done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_prog_encoder.sv
// Bench for prog_encoder: one shared stimulus drives a 256-deep and an 8-deep
// instance, each checked every cycle against a behavioural model.
module tb_prog_encoder;

    logic       clk;
    logic       rst_n;
    logic       load_go;
    logic       in_valid;
    logic [2:0] in_op;
    logic [1:0] in_bb;
    logic [2:0] in_rs;
    logic [2:0] in_rd;
    logic [5:0] in_imm;
    logic       in_last;

    logic       rdy0, we0, start0, done0, err0;
    logic [7:0] addr0;
    logic [8:0] wdata0;
    logic       rdy1, we1, start1, done1, err1;
    logic [2:0] addr1;
    logic [8:0] wdata1;

    int total;
    int bad;

    prog_encoder #(.ADDR_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .load_go(load_go), .in_valid(in_valid), .in_ready(rdy0),
        .in_op(in_op), .in_bb(in_bb), .in_rs(in_rs), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .core_start(start0), .load_done(done0), .err(err0)
    );

    prog_encoder #(.ADDR_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load_go(load_go), .in_valid(in_valid), .in_ready(rdy1),
        .in_op(in_op), .in_bb(in_bb), .in_rs(in_rs), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .core_start(start1), .load_done(done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state, one slot per instance
    int         m_phase [2];   // 0 idle, 1 loading, 2 terminator due, 3 terminator written, 4 complete
    int         m_addr  [2];
    int         m_depth [2];
    logic       e_we    [2];
    logic [7:0] e_addr  [2];
    logic [8:0] e_data  [2];
    logic       e_err   [2];
    logic       e_done  [2];
    logic       e_start [2];

    logic [8:0] cap0 [256];
    logic [8:0] cap1 [8];
    int         wr_cnt   [2];
    int         done_cnt [2];

    function automatic logic [9:0] model_pack(input int op, input int bb, input int rs,
                                              input int rd, input int imm);
        logic [31:0] w;
        logic        ovf;
        w   = op * 64;
        ovf = 1'b0;
        if (op <= 1) begin
            w = w + imm;
        end else if (op <= 3) begin
            w   = w + bb * 16 + (rs % 2) * 8 + rd;
            ovf = (rs > 1);
        end else if (op == 4) begin
            w   = w + (bb / 2) * 32 + (rs % 4) * 8 + rd;
            ovf = (rs > 3);
        end else begin
            w = w + rs * 8 + rd;
        end
        return {ovf, w[8:0]};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[dut%0d] at %0t: got %0h required %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_addr[k]  = 0;
            e_we[k]    = 1'b0;
            e_addr[k]  = 8'd0;
            e_data[k]  = 9'd0;
            e_err[k]   = 1'b0;
            e_done[k]  = 1'b0;
            e_start[k] = 1'b1;
        end
    endtask

    task automatic model_loop();
        logic [9:0] pk;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                pk = model_pack(int'(in_op), int'(in_bb), int'(in_rs), int'(in_rd), int'(in_imm));
                for (int k = 0; k < 2; k++) begin
                    e_we[k] = 1'b0;
                    case (m_phase[k])
                        1: begin
                            if (in_valid) begin
                                if (in_op == 3'd3 && in_bb == 2'd3) begin
                                    m_phase[k] = 2;
                                end else if (pk[9]) begin
                                    e_err[k] = 1'b1;
                                    if (in_last) m_phase[k] = 2;
                                end else begin
                                    e_we[k]   = 1'b1;
                                    e_addr[k] = 8'(m_addr[k]);
                                    e_data[k] = pk[8:0];
                                    m_addr[k] = m_addr[k] + 1;
                                    if (in_last) begin
                                        m_phase[k] = 2;
                                    end else if (m_addr[k] == m_depth[k] - 1) begin
                                        e_err[k]   = 1'b1;
                                        m_phase[k] = 2;
                                    end
                                end
                            end
                        end
                        2: begin
                            e_we[k]    = 1'b1;
                            e_addr[k]  = 8'(m_addr[k]);
                            e_data[k]  = 9'h0F0;
                            m_phase[k] = 3;
                        end
                        default: begin
                            if (load_go) begin
                                m_phase[k] = 1;
                                m_addr[k]  = 0;
                                e_err[k]   = 1'b0;
                                e_done[k]  = 1'b0;
                                e_start[k] = 1'b1;
                            end else if (m_phase[k] == 3) begin
                                e_done[k]  = 1'b1;
                                e_start[k] = 1'b0;
                                m_phase[k] = 4;
                            end
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic checker_loop();
        forever begin
            @(negedge clk);
            chk("in_ready",   0, 32'(rdy0),   32'(m_phase[0] == 1));
            chk("imem_we",    0, 32'(we0),    32'(e_we[0]));
            chk("imem_addr",  0, 32'(addr0),  32'(e_addr[0]));
            chk("imem_wdata", 0, 32'(wdata0), 32'(e_data[0]));
            chk("core_start", 0, 32'(start0), 32'(e_start[0]));
            chk("load_done",  0, 32'(done0),  32'(e_done[0]));
            chk("err",        0, 32'(err0),   32'(e_err[0]));
            chk("in_ready",   1, 32'(rdy1),   32'(m_phase[1] == 1));
            chk("imem_we",    1, 32'(we1),    32'(e_we[1]));
            chk("imem_addr",  1, 32'(addr1),  32'(e_addr[1]));
            chk("imem_wdata", 1, 32'(wdata1), 32'(e_data[1]));
            chk("core_start", 1, 32'(start1), 32'(e_start[1]));
            chk("load_done",  1, 32'(done1),  32'(e_done[1]));
            chk("err",        1, 32'(err1),   32'(e_err[1]));
        end
    endtask

    task automatic capture_loop();
        forever begin
            @(negedge clk);
            if (we0) begin
                cap0[addr0] = wdata0;
                wr_cnt[0]++;
                if (wdata0 == 9'h0F0) done_cnt[0]++;
            end
            if (we1) begin
                cap1[addr1] = wdata1;
                wr_cnt[1]++;
                if (wdata1 == 9'h0F0) done_cnt[1]++;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go();
        for (int k = 0; k < 2; k++) begin
            wr_cnt[k]   = 0;
            done_cnt[k] = 0;
        end
        load_go = 1'b1;
        tick(1);
        load_go = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] bb, input logic [2:0] rs,
                        input logic [2:0] rd, input logic [5:0] imm, input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_bb    = bb;
        in_rs    = rs;
        in_rd    = rd;
        in_imm   = imm;
        in_last  = last;
        $display("bundle op=%0d bb=%0d rs=%0d rd=%0d imm=%0h last=%0d", op, bb, rs, rd, imm, last);
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!(done0 && done1) && c < 40) begin
            tick(1);
            c++;
        end
        total++;
        if (!(done0 && done1)) begin
            bad++;
            $display("FAIL %s load_done timeout: got %b%b required 11", tag, done0, done1);
        end
    endtask

    initial begin
        m_depth[0] = 256;
        m_depth[1] = 8;
        total = 0;
        bad   = 0;
        model_reset();
        rst_n = 1'b0;
        load_go = 1'b0;
        in_valid = 1'b0;
        in_op = '0; in_bb = '0; in_rs = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
        fork
            model_loop();
        join_none
        tick(3);
        rst_n = 1'b1;
        fork
            checker_loop();
            capture_loop();
        join_none

        // Model pinned against hand-encoded words
        chk("pack_add",  0, 32'(model_pack(7, 0, 2, 5, 0)),    32'h1D5);
        chk("pack_addi", 0, 32'(model_pack(0, 0, 0, 0, 42)),   32'h02A);
        chk("pack_br",   0, 32'(model_pack(2, 1, 1, 3, 0)),    32'h09B);
        chk("pack_shf",  0, 32'(model_pack(4, 2, 3, 1, 0)),    32'h139);
        chk("pack_ovf",  0, 32'(model_pack(2, 0, 2, 0, 0) >> 9), 32'h1);
        tick(1);
        chk("rst_start", 0, 32'(start0), 32'h1);
        chk("rst_ready", 0, 32'(rdy0),   32'h0);

        // Basic three-instruction program
        go();
        send(3'd7, 2'd0, 3'd2, 3'd5, 6'h00, 1'b0);
        send(3'd0, 2'd0, 3'd0, 3'd0, 6'h2A, 1'b0);
        send(3'd2, 2'd1, 3'd1, 3'd3, 6'h00, 1'b1);
        wait_done("basic");
        chk("basic_w0", 0, 32'(cap0[0]), 32'h1D5);
        chk("basic_w1", 0, 32'(cap0[1]), 32'h02A);
        chk("basic_w2", 0, 32'(cap0[2]), 32'h09B);
        chk("basic_w3", 0, 32'(cap0[3]), 32'h0F0);
        chk("basic_cnt", 0, 32'(wr_cnt[0]), 32'd4);
        chk("basic_start", 0, 32'(start0), 32'h0);
        chk("basic_err", 0, 32'(err0), 32'h0);

        // Field overflow is dropped without advancing the address
        go();
        send(3'd4, 2'd2, 3'd3, 3'd1, 6'h00, 1'b0);
        send(3'd2, 2'd0, 3'd2, 3'd0, 6'h00, 1'b0);
        chk("ovf_err", 0, 32'(err0), 32'h1);
        chk("ovf_cnt", 0, 32'(wr_cnt[0]), 32'd1);
        send(3'd5, 2'd0, 3'd1, 3'd2, 6'h00, 1'b1);
        wait_done("ovf");
        chk("ovf_w0", 0, 32'(cap0[0]), 32'h139);
        chk("ovf_w1", 0, 32'(cap0[1]), 32'h14A);
        chk("ovf_w2", 0, 32'(cap0[2]), 32'h0F0);
        chk("ovf_err_end", 0, 32'(err0), 32'h1);

        // User-supplied done bundle terminates with a single done word
        go();
        send(3'd0, 2'd0, 3'd0, 3'd0, 6'h05, 1'b0);
        send(3'd3, 2'd3, 3'd0, 3'd0, 6'h00, 1'b0);
        send(3'd6, 2'd0, 3'd1, 3'd1, 6'h00, 1'b0);
        wait_done("doneop");
        chk("doneop_w0", 0, 32'(cap0[0]), 32'h005);
        chk("doneop_w1", 0, 32'(cap0[1]), 32'h0F0);
        chk("doneop_cnt", 0, 32'(wr_cnt[0]), 32'd2);
        chk("doneop_dcnt", 0, 32'(done_cnt[0]), 32'd1);

        // Capacity: the 8-deep instance fills up, the 256-deep one does not
        go();
        for (int i = 1; i <= 8; i++) send(3'd0, 2'd0, 3'd0, 3'd0, 6'(i), 1'b0);
        send(3'd0, 2'd0, 3'd0, 3'd0, 6'd9, 1'b1);
        wait_done("cap");
        chk("cap_w6", 1, 32'(cap1[6]), 32'h007);
        chk("cap_w7", 1, 32'(cap1[7]), 32'h0F0);
        chk("cap_cnt", 1, 32'(wr_cnt[1]), 32'd8);
        chk("cap_err", 1, 32'(err1), 32'h1);
        chk("cap_big_cnt", 0, 32'(wr_cnt[0]), 32'd10);
        chk("cap_big_w9", 0, 32'(cap0[9]), 32'h0F0);
        chk("cap_big_err", 0, 32'(err0), 32'h0);

        // Gap in in_valid
        go();
        send(3'd7, 2'd0, 3'd1, 3'd1, 6'h00, 1'b0);
        tick(1);
        send(3'd7, 2'd0, 3'd2, 3'd2, 6'h00, 1'b1);
        wait_done("gap");
        chk("gap_w0", 0, 32'(cap0[0]), 32'h1C9);
        chk("gap_w1", 0, 32'(cap0[1]), 32'h1D2);
        chk("gap_w2", 0, 32'(cap0[2]), 32'h0F0);
        chk("gap_cnt", 0, 32'(wr_cnt[0]), 32'd3);

        // Asynchronous reset mid-session, then restart from address 0
        go();
        send(3'd7, 2'd0, 3'd1, 3'd1, 6'h00, 1'b0);
        send(3'd0, 2'd0, 3'd0, 3'd0, 6'h03, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",   0, 32'(wr_cnt[0]), 32'd2);
        chk("arst_we",    0, 32'(we0),    32'h0);
        chk("arst_addr",  0, 32'(addr0),  32'h0);
        chk("arst_wdata", 0, 32'(wdata0), 32'h0);
        chk("arst_ready", 0, 32'(rdy0),   32'h0);
        chk("arst_start", 0, 32'(start0), 32'h1);
        chk("arst_done",  0, 32'(done0),  32'h0);
        chk("arst_err",   0, 32'(err0),   32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        go();
        send(3'd7, 2'd0, 3'd2, 3'd5, 6'h00, 1'b1);
        wait_done("restart");
        chk("restart_w0", 0, 32'(cap0[0]), 32'h1D5);
        chk("restart_w1", 0, 32'(cap0[1]), 32'h0F0);
        chk("restart_cnt", 0, 32'(wr_cnt[0]), 32'd2);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_encoder.md
# prog_encoder

Sequential instruction encoder and loader feeding the 9-bit core's instruction memory. Accepts decoded instruction fields (opcode, branch/sub-op bits, register fields, immediate) over a valid/ready stream. Packs each into a 9-bit machine word and writes it to consecutive instruction-memory addresses. Terminates the program with an automatically appended `done` word and holds the core in `start` until loading completes.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory address width; depth `2**ADDR_W`.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_go`  in  1  pulse; starts a load session from address 0.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  block accepts the bundle this cycle.
- `in_op`  in  3  opcode.
- `in_bb`  in  2  branch/sub-op bits.
- `in_rs`  in  3  source register / shift amount field.
- `in_rd`  in  3  destination register.
- `in_imm`  in  6  immediate or jump offset.
- `in_last`  in  1  bundle is the final user instruction.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  9  encoded word.
- `core_start`  out  1  holds the core in its start state while high.
- `load_done`  out  1  level; session finished.
- `err`  out  1  sticky; a field overflow or capacity overrun occurred.

## Operation
Encoding, with `w[8:6] = in_op` in all classes:
- I-type (000) and jump (001): `w[5:0] = in_imm`.
- B (010) and mem (011): `w[5:4] = in_bb`, `w[3] = in_rs[0]`, `w[2:0] = in_rd`. `in_rs > 1` is an overflow.
- S (100): `w[5] = in_bb[1]` (shift left), `w[4:3] = in_rs[1:0]`, `w[2:0] = in_rd`. `in_rs > 3` is an overflow.
- R (101/110/111): `w[5:3] = in_rs`, `w[2:0] = in_rd`.
- Overflowed bundle: it is accepted and dropped. No write occurs, the address is not advanced, and `err` is set.
- User bundle `op=011, bb=11` (`done`) is treated as `in_last`. The done word itself is written in FINISH, not twice.

FSM states and transitions:
- IDLE → LOAD on `load_go`. On entry: address counter ← 0, `err` ← 0, `load_done` ← 0.
- LOAD: `in_ready=1`. On each handshake, register the encoded word and address.
  - Last bundle → FINISH.
  - Non-last bundle accepted at `addr == 2**ADDR_W-2` → set `err`, go to FINISH. This slot is the final user slot; the top address is reserved for `done`.
- FINISH: write `9'h0F0` (`011_11_0000`) at the current address → DONE.
- DONE: `core_start=0`, `load_done=1`. `load_go` re-enters LOAD (new session).
- `load_go` during LOAD or FINISH is ignored.

## Timing
- Reset values: state IDLE, addr 0, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `in_ready=0`, `core_start=1`, `load_done=0`, `err=0`.
- `core_start` is high in IDLE, LOAD and FINISH, and low only in DONE.
- Throughput is one bundle per cycle.
- Write latency is 1: a bundle handshaken at edge N produces `imem_we=1` with its addr/data during cycle N+1.
- The done word's write strobe is the cycle after the last handshake. `load_done` rises on the following edge.
- `in_ready` is a function of state only and never depends on `in_valid`.
- Reset mid-session aborts immediately. No further writes occur, and `core_start` returns to 1.

## Structure
- Shared package `isa_pkg`:
  - opcode constants (`OP_ADDI=3'b000`, `OP_J=3'b001`, `OP_BR=3'b010`, `OP_MEM=3'b011`, `OP_SHF=3'b100`, `OP_XOR=3'b101`, `OP_AND=3'b110`, `OP_ADD=3'b111`);
  - `DONE_WORD=9'h0F0`;
  - the FSM state enum.
- One combinational sub-module, `instr_pack`: fields in → 9-bit word plus overflow flag out. The FSM, address counter and output registers stay in `prog_encoder`.

## Test plan
- Reset, then `load_go`, then bundles ADD rs=2 rd=5, ADDI imm=0x2A, BR bb=01 rs=1 rd=3 (last). Required writes: 0:`0x1D5`, 1:`0x02A`, 2:`0x09B`, 3:`0x0F0`. `load_done=1`, `core_start=0`, `err=0`.
- Shift bundle bb=10 rs=3 rd=1 → `0x139`. Then BR rs=2 → no write, addr unchanged, `err=1`; the next bundle lands at the same address.
- User sends `op=011 bb=11` mid-stream → exactly one `0x0F0` written, at the next address. No second done word.
- `ADDR_W=3`: send 8 non-last bundles. The first 7 are written at 0-6, the 8th is not accepted, then `0x0F0` is written at 7 and `err=1`.
- `in_valid` toggling 1,0,1 with `in_ready` high → exactly two writes, with contiguous addresses.
- Assert `rst_n=0` during LOAD after 2 writes → all outputs at reset values asynchronously. A new `load_go` restarts the load at address 0.
